// File: rtl/fifo_packer_arb_pkg.sv
// rtl/fifo_packer_arb_pkg.sv - shared types, limits and index-width helper for fifo_packer_arbiter
package fifo_packer_arb_pkg;

    localparam int C_MAX_CHNL = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // A single requester still gets a 1-bit index so ports never collapse to zero width.
    function automatic int chnl_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin pick starting one past the last grant
module rr_priority_select
    import fifo_packer_arb_pkg::*;
#(
    parameter int C_N = 4,
    parameter int C_W = chnl_idx_w(C_N)
) (
    input  logic [C_N-1:0] i_req,
    input  logic [C_W-1:0] i_last,
    output logic [C_N-1:0] o_onehot,
    output logic [C_W-1:0] o_idx,
    output logic           o_valid
);

    // Walk from farthest to nearest so the nearest set bit after i_last overwrites the rest.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int k = C_N; k >= 1; k--) begin
            if (i_req[C_W'((int'(i_last) + k) % C_N)]) begin
                o_onehot                                  = '0;
                o_onehot[C_W'((int'(i_last) + k) % C_N)]  = 1'b1;
                o_idx                                     = C_W'((int'(i_last) + k) % C_N);
                o_valid                                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_packer_arbiter.sv
// rtl/fifo_packer_arbiter.sv - round-robin share of one packer datapath; watchdog via FIFO_PACKER_ARB_TIMEOUT_EN
module fifo_packer_arbiter
    import fifo_packer_arb_pkg::*;
#(
    parameter int C_NUM_CHNL = 4,
    parameter int C_TIMEOUT  = 256,
    localparam int C_IDX_W   = chnl_idx_w(C_NUM_CHNL)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [C_NUM_CHNL-1:0]    i_req,
    input  logic [32*C_NUM_CHNL-1:0] i_req_data,
    input  logic [C_NUM_CHNL-1:0]    i_req_data_en,
    input  logic [C_NUM_CHNL-1:0]    i_req_data_done,
    input  logic [C_NUM_CHNL-1:0]    i_req_data_err,
    input  logic [C_NUM_CHNL-1:0]    i_req_data_flush,
    output logic [C_NUM_CHNL-1:0]    o_gnt,
    output logic [31:0]              o_pk_data,
    output logic                     o_pk_data_en,
    output logic                     o_pk_data_done,
    output logic                     o_pk_data_err,
    output logic                     o_pk_data_flush,
    output logic [C_IDX_W-1:0]       o_active_chnl
);

    if (C_NUM_CHNL < 1 || C_NUM_CHNL > C_MAX_CHNL || C_TIMEOUT < 1) begin : g_bad_param
        $error("fifo_packer_arbiter: parameter out of range");
    end

    arb_state_t              r_state, w_state_nxt;
    logic [C_NUM_CHNL-1:0]   r_gnt, w_gnt_nxt;
    logic [C_IDX_W-1:0]      r_active, w_active_nxt;
    logic [C_IDX_W-1:0]      r_last, w_last_nxt;
    logic [31:0]             r_pk_data, w_pk_data_nxt;
    logic                    r_pk_en, w_pk_en_nxt;
    logic                    r_pk_done, w_pk_done_nxt;
    logic                    r_pk_err, w_pk_err_nxt;
    logic                    r_pk_flush, w_pk_flush_nxt;

    logic [C_NUM_CHNL-1:0]   w_pick_onehot;
    logic [C_IDX_W-1:0]      w_pick_idx;
    logic                    w_pick_valid;

    logic [31:0]             w_data_arr [C_NUM_CHNL];
    logic [31:0]             w_sel_data;
    logic                    w_sel_en;
    logic                    w_sel_done;
    logic                    w_sel_err;
    logic                    w_sel_flush;

`ifdef FIFO_PACKER_ARB_TIMEOUT_EN
    localparam int C_WD_W = $clog2(C_TIMEOUT + 1);
    logic [C_WD_W-1:0]       r_wd, w_wd_nxt;
`endif

    for (genvar g = 0; g < C_NUM_CHNL; g++) begin : g_unpack
        assign w_data_arr[g] = i_req_data[32*g +: 32];
    end

    // Only the granted channel is ever looked at; everyone else is ignored outright.
    assign w_sel_data  = w_data_arr[r_active];
    assign w_sel_en    = i_req_data_en[r_active];
    assign w_sel_done  = i_req_data_done[r_active];
    assign w_sel_err   = i_req_data_err[r_active];
    assign w_sel_flush = i_req_data_flush[r_active];

    rr_priority_select #(
        .C_N (C_NUM_CHNL),
        .C_W (C_IDX_W)
    ) u_rr_sel (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_active_nxt   = r_active;
        w_last_nxt     = r_last;
        w_pk_data_nxt  = r_pk_data;
        w_pk_en_nxt    = 1'b0;
        w_pk_done_nxt  = 1'b0;
        w_pk_err_nxt   = 1'b0;
        w_pk_flush_nxt = 1'b0;
`ifdef FIFO_PACKER_ARB_TIMEOUT_EN
        w_wd_nxt       = r_wd;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt  = ST_BUSY;
                    w_gnt_nxt    = w_pick_onehot;
                    w_active_nxt = w_pick_idx;
                    w_last_nxt   = w_pick_idx;
`ifdef FIFO_PACKER_ARB_TIMEOUT_EN
                    w_wd_nxt     = '0;
`endif
                end
            end
            ST_BUSY: begin
                w_pk_en_nxt    = w_sel_en;
                w_pk_done_nxt  = w_sel_done;
                w_pk_err_nxt   = w_sel_done & w_sel_err;
                w_pk_flush_nxt = w_sel_flush;
                if (w_sel_en) begin
                    w_pk_data_nxt = w_sel_data;
                end
                if (w_sel_done) begin
                    w_state_nxt = ST_RELEASE;
                    w_gnt_nxt   = '0;
                end
`ifdef FIFO_PACKER_ARB_TIMEOUT_EN
                else if (w_sel_en) begin
                    w_wd_nxt = '0;
                end else if (r_wd == C_WD_W'(C_TIMEOUT - 1)) begin
                    // Stalled packet: close it with an error so the packer can resynchronise.
                    w_pk_done_nxt = 1'b1;
                    w_pk_err_nxt  = 1'b1;
                    w_state_nxt   = ST_RELEASE;
                    w_gnt_nxt     = '0;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_active   <= '0;
            r_last     <= C_IDX_W'(C_NUM_CHNL - 1);
            r_pk_data  <= '0;
            r_pk_en    <= 1'b0;
            r_pk_done  <= 1'b0;
            r_pk_err   <= 1'b0;
            r_pk_flush <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_active   <= w_active_nxt;
            r_last     <= w_last_nxt;
            r_pk_data  <= w_pk_data_nxt;
            r_pk_en    <= w_pk_en_nxt;
            r_pk_done  <= w_pk_done_nxt;
            r_pk_err   <= w_pk_err_nxt;
            r_pk_flush <= w_pk_flush_nxt;
        end
    end

`ifdef FIFO_PACKER_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd <= '0;
        end else begin
            r_wd <= w_wd_nxt;
        end
    end
`endif

    assign o_gnt           = r_gnt;
    assign o_active_chnl   = r_active;
    assign o_pk_data       = r_pk_data;
    assign o_pk_data_en    = r_pk_en;
    assign o_pk_data_done  = r_pk_done;
    assign o_pk_data_err   = r_pk_err;
    assign o_pk_data_flush = r_pk_flush;

endmodule

// File: doc/fifo_packer_arbiter.md
# fifo_packer_arbiter

Shares one 32-bit packer datapath between up to 12 channel sources in the RX path. Each source requests the packer, is granted exclusive use for a whole packet, and its data/done/error/flush signals are forwarded, registered, to the packer inputs. Grants rotate round-robin, so no channel starves. The block sits between the per-channel receive engines and the single fifo_packer instance feeding the shared RX FIFO.

## Interface
- C_NUM_CHNL, 4: number of requesters, legal range 1..12.
- C_TIMEOUT, 256: idle cycles before a stalled packet is aborted. Used only with the timeout feature.
- CLK  in  1  clock; all logic is rising-edge.
- RST_N  in  1  reset, asynchronous and active-low; one clock; reset is asynchronous, active-low.
- REQ  in  C_NUM_CHNL  per-channel request, level.
- REQ_DATA  in  32*C_NUM_CHNL  per-channel data; channel i occupies bits [32i+31:32i].
- REQ_DATA_EN  in  C_NUM_CHNL  per-channel data valid.
- REQ_DATA_DONE  in  C_NUM_CHNL  per-channel end-of-packet pulse.
- REQ_DATA_ERR  in  C_NUM_CHNL  per-channel error, qualified by DONE.
- REQ_DATA_FLUSH  in  C_NUM_CHNL  per-channel end-of-data pulse.
- GNT  out  C_NUM_CHNL  one-hot grant, registered.
- PK_DATA  out  32  data to packer.
- PK_DATA_EN  out  1  data valid to packer.
- PK_DATA_DONE  out  1  end of packet to packer.
- PK_DATA_ERR  out  1  error to packer.
- PK_DATA_FLUSH  out  1  flush to packer.
- ACTIVE_CHNL  out  max(1,clog2(C_NUM_CHNL))  index of the granted channel; holds the last grant when idle.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: if any REQ bit is set, select the first set bit searching from (last+1) mod C_NUM_CHNL. Register GNT and ACTIVE_CHNL, then go to BUSY. After reset, last = C_NUM_CHNL-1, so channel 0 has first priority.
- BUSY: only the granted channel's EN/DONE/ERR/FLUSH/DATA are forwarded. All other channels' inputs are ignored, and their EN is dropped silently.
- BUSY: granted DONE → forward it with ERR and go to RELEASE. EN and DONE in the same cycle forward both.
- BUSY: FLUSH from the granted channel is forwarded and does not end the grant.
- BUSY: REQ deasserted by the granted channel does not release the grant; only DONE (or timeout) releases it.
- RELEASE: GNT all-zero for exactly one cycle, then IDLE.
- C_NUM_CHNL=1: same FSM; GNT toggles around every packet.
- PK_DATA is unconstrained when PK_DATA_EN=0.

## Timing
- Reset values:
  - GNT = 0, PK_DATA_EN/DONE/ERR/FLUSH = 0, PK_DATA = 0, ACTIVE_CHNL = 0.
  - State = IDLE.
- Reset asserted mid-packet clears all outputs immediately (asynchronously). No DONE is emitted for the aborted packet.
- REQ seen in IDLE at cycle t → GNT at t+1.
- Granted input at cycle k → PK_* at k+1 (one-register latency, no bubbles).
- Granted DONE at d:
  - PK_DATA_DONE at d+1, GNT=0 at d+1.
  - Earliest next GNT at d+3.
- Back-to-back packets from the same channel are rearbitrated each time; another requester present wins.

## Configuration
- FIFO_PACKER_ARB_TIMEOUT_EN defined: a watchdog counter runs in BUSY.
  - The counter clears on every granted EN or entry to BUSY.
  - At C_TIMEOUT consecutive cycles with no EN and no DONE, the block emits PK_DATA_DONE=1 and PK_DATA_ERR=1 for one cycle, drops GNT, and enters RELEASE.
  - Later inputs from that channel are ignored until it is granted again.
- Undefined: no counter; a stalled requester holds the grant indefinitely.

## Structure
- Package fifo_packer_arb_pkg:
  - state enum (IDLE, BUSY, RELEASE);
  - C_MAX_CHNL=12;
  - channel-index width function.
- Sub-module rr_priority_select: combinational round-robin pick from a request vector and last-grant index. Outputs a one-hot vector, an index and a valid flag.

## Test plan
- Reset, then REQ=4'b0001; ch0 sends 3 words 0xA0..0xA2 with DONE on the third:
  - GNT=0001 one cycle after REQ;
  - PK_DATA shows A0,A1,A2, each one cycle after its input;
  - PK_DATA_DONE on the A2 cycle+1; GNT=0 the same cycle.
- REQ=4'b1111 held, each channel sends 1-word packets:
  - grant order 0,1,2,3,0;
  - 3-cycle spacing between grants.
- Ch1 granted; ch2 drives EN with 0xDEAD meanwhile:
  - 0xDEAD never appears on PK_DATA;
  - ch1 data unaffected.
- Ch0 granted, drives EN+DONE+ERR in one cycle with 0x55:
  - next cycle PK_DATA=0x55, EN=DONE=ERR=1.
- Ch3 granted, sends 2 words; RST_N pulsed low before DONE:
  - all outputs 0 while reset is low;
  - after release REQ=4'b1000 re-grants ch3, because last priority resets to channel 0 search.
- With FIFO_PACKER_ARB_TIMEOUT_EN, C_TIMEOUT=8; ch2 sends one word then goes silent:
  - 8 idle cycles later PK_DATA_DONE=PK_DATA_ERR=1 and GNT drops;
  - without the macro GNT stays 0100 for 100 cycles.
